cms_and_serial_ctrl: RTL and testbench
======================================

CMS_AND_SERIAL_CTRL -- requirements
Module: cms_and_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand bit-width (range 1..64).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, operand-valid request.
REQ-005 SHALL have port ready_o, output, 1, controller idle and able to accept operands.
REQ-006 SHALL have port X_i, input, 4*WIDTH, shares of X; share s at bits [s*WIDTH +: WIDTH].
REQ-007 SHALL have port Y_i, input, 4*WIDTH, shares of Y; same packing.
REQ-008 SHALL have port rnd_valid_i, input, 1, fresh 16-bit randomness available.
REQ-009 SHALL have port rnd_i, input, 16, randomness word; bit j feeds gadget Zj.
REQ-010 SHALL have port rnd_ready_o, output, 1, randomness word consumed this cycle.
REQ-011 SHALL have port g_x_o, output, 4, current X share bits to gadget (bit s = Xs).
REQ-012 SHALL have port g_y_o, output, 4, current Y share bits to gadget.
REQ-013 SHALL have port g_z_o, output, 16, randomness to gadget Z0..Z15.
REQ-014 SHALL have port g_q_i, input, 4, gadget output shares Q0..Q3 (gadget registers, 1-cycle latency, reset via same rst_i).
REQ-015 SHALL have port out_valid_o, output, 1, result shares valid.
REQ-016 SHALL have port out_ready_i, input, 1, downstream accepts result.
REQ-017 SHALL have port Q_o, output, 4*WIDTH, result shares; same packing as X_i.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE; ready_o=1 only in IDLE.
REQ-019 SHALL, in IDLE with start_i=1, latch X_i and Y_i, clear bit index k to 0, clear result register, go to ISSUE.
REQ-020 SHALL ignore start_i outside IDLE; latched operands stay unchanged.
REQ-021 SHALL, in ISSUE with rnd_valid_i=1: drive g_x_o/g_y_o with share bits k of latched X/Y, g_z_o=rnd_i, rnd_ready_o=1, set issue tag with index k, increment k.
REQ-022 SHALL, in ISSUE with rnd_valid_i=0: stall, rnd_ready_o=0, g_x_o=g_y_o=0, g_z_o=0, issue tag clear; k unchanged.
REQ-023 SHALL drive g_x_o, g_y_o, g_z_o, rnd_ready_o to 0 in every state other than an issuing ISSUE cycle; no operand share reaches the gadget unpaired with a fresh word.
REQ-024 SHALL consume each randomness word exactly once; rnd_ready_o never asserted without rnd_valid_i.
REQ-025 SHALL, one cycle after a tagged issue, write g_q_i[s] into result bit k of share s, for s=0..3.
REQ-026 SHALL go ISSUE->DRAIN on the cycle issuing bit WIDTH-1; DRAIN lasts exactly one cycle (captures last bit) then DONE.
REQ-027 SHALL, in DONE, hold out_valid_o=1 and Q_o stable until out_ready_i=1, then go to IDLE next cycle.
REQ-028 SHALL give latency, with rnd_valid_i continuously high, of WIDTH+2 cycles from start accept to out_valid_o high.
REQ-029 SHALL keep Q_o equal to the result register at all times; XOR of the four Q_o shares equals (XOR of X shares) AND (XOR of Y shares) bitwise.
REQ-030 SHALL size k as clog2(WIDTH+1) bits; no wrap-around; WIDTH=1 goes ISSUE->DRAIN after one issue.
REQ-031 SHALL not accept a new start in the cycle out_ready_i completes DONE; earliest accept is the following IDLE cycle.

Reset
REQ-032 SHALL, on rst_i=1 at any time including mid-ISSUE, go to IDLE immediately: ready_o=1, out_valid_o=0, rnd_ready_o=0, g_x_o=g_y_o=0, g_z_o=0, Q_o=0, k=0, issue tag clear, latched operands 0.
REQ-033 SHALL, after rst_i deasserts, resume in IDLE with no partial result retained or emitted.

Verification
REQ-034 SHALL cover WIDTH=8, X=0xA5, Y=0x3C (random sharings), rnd_valid_i=1 always -> out_valid_o at cycle 10 after accept, unmasked Q=0x24, 8 rnd_ready_o pulses.
REQ-035 SHALL cover rnd_valid_i low on 3 random cycles during ISSUE -> g_x_o/g_y_o/g_z_o zero on those cycles, result still 0x24, latency 13.
REQ-036 SHALL cover out_ready_i held low 5 cycles in DONE -> Q_o stable, ready_o=0, start_i ignored; then single-cycle handshake -> IDLE.
REQ-037 SHALL cover rst_i pulse at bit k=4 -> all outputs at reset values same cycle; new op X=0xFF, Y=0x0F -> Q=0x0F.
REQ-038 SHALL cover X=0xFF, Y=0xFF -> Q=0xFF; X=0x00 -> Q=0x00; each rnd word observed on g_z_o exactly once.

Source files
------------

// File: rtl/cms_and_serial_ctrl.sv
// Bit-serial controller for a 4-share masked AND gadget: issues one bit per
// fresh randomness word, gathers the gadget's registered output shares and
// hands back the complete shared result.
module cms_and_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [4*WIDTH-1:0]   X_i,
  input  logic [4*WIDTH-1:0]   Y_i,
  input  logic                 rnd_valid_i,
  input  logic [15:0]          rnd_i,
  output logic                 rnd_ready_o,
  output logic [3:0]           g_x_o,
  output logic [3:0]           g_y_o,
  output logic [15:0]          g_z_o,
  input  logic [3:0]           g_q_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*WIDTH-1:0]   Q_o
);

  localparam int unsigned NSH = 4;
  localparam int unsigned KW  = $clog2(WIDTH + 1);
  localparam int unsigned VW  = NSH * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [VW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic [VW-1:0]   res_q, res_d;
  logic            tag_vld_q, tag_vld_d;
  logic [KW-1:0]   tag_idx_q, tag_idx_d;
  logic            issue_c;

  // Bit i of one share; the index may be one wider than a share needs.
  function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [KW-1:0] i);
    logic [WIDTH-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Share v with bit i replaced by b.
  function automatic logic [WIDTH-1:0] set_bit(input logic [WIDTH-1:0] v,
                                               input logic [KW-1:0] i,
                                               input logic b);
    logic [WIDTH-1:0] m;
    m = WIDTH'(1) << i;
    return b ? (v | m) : (v & ~m);
  endfunction

  // A bit is issued only when a fresh randomness word pairs with it.
  assign issue_c     = (state_q == ISSUE) && rnd_valid_i;
  assign rnd_ready_o = issue_c;
  assign g_z_o       = issue_c ? rnd_i : 16'h0000;
  assign ready_o     = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign Q_o         = res_q;

  // Share bits k of the latched operands, gated to zero outside issue cycles.
  always_comb begin
    g_x_o = 4'h0;
    g_y_o = 4'h0;
    if (issue_c) begin
      for (int s = 0; s < NSH; s++) begin
        g_x_o[s] = bit_at(x_q[s*WIDTH +: WIDTH], k_q);
        g_y_o[s] = bit_at(y_q[s*WIDTH +: WIDTH], k_q);
      end
    end
  end

  // Next-state, bit index, issue tag and result capture.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    tag_vld_d = 1'b0;
    tag_idx_d = tag_idx_q;

    if (tag_vld_q) begin
      for (int s = 0; s < NSH; s++) begin
        res_d[s*WIDTH +: WIDTH] = set_bit(res_q[s*WIDTH +: WIDTH], tag_idx_q, g_q_i[s]);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = X_i;
          y_d     = Y_i;
          k_d     = '0;
          res_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rnd_valid_i) begin
          tag_vld_d = 1'b1;
          tag_idx_d = k_q;
          k_d       = k_q + KW'(1);
          if (k_q == KW'(WIDTH - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      res_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      res_q     <= res_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

endmodule

// File: tb/tb_cms_and_serial_ctrl.sv
// Directed bench for cms_and_serial_ctrl with a behavioural 4-share AND gadget.
module tb_cms_and_serial_ctrl;

  localparam int W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              ready_o;
  logic [4*W-1:0]    X_i = '0;
  logic [4*W-1:0]    Y_i = '0;
  logic              rnd_valid_i = 1'b0;
  logic [15:0]       rnd_i = '0;
  logic              rnd_ready_o;
  logic [3:0]        g_x_o;
  logic [3:0]        g_y_o;
  logic [15:0]       g_z_o;
  logic [3:0]        g_q_i;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [4*W-1:0]    Q_o;

  int                checks = 0;
  int                errors = 0;
  logic [15:0]       rnd_word = 16'h1000;

  cms_and_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .X_i(X_i), .Y_i(Y_i), .rnd_valid_i(rnd_valid_i), .rnd_i(rnd_i),
    .rnd_ready_o(rnd_ready_o), .g_x_o(g_x_o), .g_y_o(g_y_o), .g_z_o(g_z_o),
    .g_q_i(g_q_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .Q_o(Q_o)
  );

  always #5 clk_i = ~clk_i;

  // Masked AND: share i gets x_i & (xor of y), refreshed by z0..z2 that cancel.
  function automatic logic [3:0] gadget(input logic [3:0] x, input logic [3:0] y,
                                        input logic [15:0] z);
    logic [3:0] q;
    for (int i = 0; i < 4; i++) q[i] = x[i] & (^y);
    q[0] = q[0] ^ z[0] ^ z[1] ^ z[2];
    q[1] = q[1] ^ z[0];
    q[2] = q[2] ^ z[1];
    q[3] = q[3] ^ z[2];
    return q;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) g_q_i <= 4'h0;
    else       g_q_i <= gadget(g_x_o, g_y_o, g_z_o);
  end

  function automatic logic [W-1:0] unmask(input logic [4*W-1:0] v);
    return v[0 +: W] ^ v[W +: W] ^ v[2*W +: W] ^ v[3*W +: W];
  endfunction

  function automatic logic [4*W-1:0] share(input logic [W-1:0] v);
    logic [4*W-1:0] s;
    s[W +: 3*W] = 24'($urandom);
    s[0 +: W]   = v ^ s[W +: W] ^ s[2*W +: W] ^ s[3*W +: W];
    return s;
  endfunction

  // One full operation: stall pattern on ISSUE cycles, 'hold' DONE cycles of back-pressure.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [31:0] stall, input int hold,
                        output logic [W-1:0] qv, output int lat, output int pulses);
    logic [4*W-1:0] xs, ys, qs;
    logic [3:0] gx, gy;
    int kb, cyc;
    bit done, exp_iss;
    xs = share(xv);
    ys = share(yv);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL op_ready got %0b exp 1", ready_o);
    end
    X_i = xs; Y_i = ys; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; X_i = ~xs; Y_i = ~ys;
    cyc = 1; kb = 0; pulses = 0; done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      rnd_valid_i = !stall[i];
      rnd_i = rnd_word;
      #1;
      exp_iss = (kb < W) && rnd_valid_i;
      for (int s = 0; s < 4; s++) begin
        gx[s] = xs[s*W + kb];
        gy[s] = ys[s*W + kb];
      end
      checks++;
      if (exp_iss) begin
        if (rnd_ready_o !== 1'b1 || g_z_o !== rnd_word || g_x_o !== gx || g_y_o !== gy) begin
          errors++;
          $display("FAIL issue k=%0d got rdy=%0b z=%h x=%h y=%h exp rdy=1 z=%h x=%h y=%h",
                   kb, rnd_ready_o, g_z_o, g_x_o, g_y_o, rnd_word, gx, gy);
        end
        rnd_word = rnd_word + 16'd1;
        kb++;
        pulses++;
      end else if (rnd_ready_o !== 1'b0 || g_z_o !== 16'h0 || g_x_o !== 4'h0 || g_y_o !== 4'h0) begin
        errors++;
        $display("FAIL quiet_drive k=%0d got rdy=%0b z=%h x=%h y=%h exp all zero",
                 kb, rnd_ready_o, g_z_o, g_x_o, g_y_o);
      end
      @(posedge clk_i); #1;
      cyc++;
      if (out_valid_o === 1'b1) done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL out_valid_timeout got 0 exp 1 within 64 cycles");
    end
    lat = cyc;
    qs = Q_o;
    qv = unmask(qs);
    rnd_valid_i = 1'b1;
    for (int h = 0; h < hold; h++) begin
      out_ready_i = 1'b0; start_i = 1'b1; X_i = $urandom; Y_i = $urandom;
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || ready_o !== 1'b0 || Q_o !== qs || rnd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL done_hold h=%0d got v=%0b r=%0b q=%h rr=%0b exp v=1 r=0 q=%h rr=0",
                 h, out_valid_o, ready_o, Q_o, rnd_ready_o, qs);
      end
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0; start_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL handshake got v=%0b r=%0b exp v=0 r=1", out_valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rnd_valid_i = 1'b1; rnd_i = 16'hBEEF; start_i = 1'b1;
    #12;
    checks++;
    if (ready_o !== 1'b1 || out_valid_o !== 1'b0 || rnd_ready_o !== 1'b0 ||
        g_x_o !== 4'h0 || g_y_o !== 4'h0 || g_z_o !== 16'h0 || Q_o !== '0) begin
      errors++;
      $display("FAIL reset_state got r=%0b v=%0b rr=%0b z=%h q=%h exp r=1 v=0 rr=0 z=0 q=0",
               ready_o, out_valid_o, rnd_ready_o, g_z_o, Q_o);
    end
    start_i = 1'b0; rnd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] q; int lat, p;
    run_op(8'hA5, 8'h3C, 32'h0, 0, q, lat, p);
    checks++;
    if (q !== 8'h24) begin errors++; $display("FAIL basic_result got %h exp 24", q); end
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d exp 10", lat); end
    checks++;
    if (p !== 8) begin errors++; $display("FAIL basic_pulses got %0d exp 8", p); end
  endtask

  task automatic test_stall();
    logic [W-1:0] q; int lat, p;
    run_op(8'hA5, 8'h3C, 32'h0000_004A, 0, q, lat, p);
    checks++;
    if (q !== 8'h24) begin errors++; $display("FAIL stall_result got %h exp 24", q); end
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL stall_latency got %0d exp 13", lat); end
    checks++;
    if (p !== 8) begin errors++; $display("FAIL stall_pulses got %0d exp 8", p); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q; int lat, p;
    run_op(8'hA5, 8'h3C, 32'h0, 5, q, lat, p);
    checks++;
    if (q !== 8'h24) begin errors++; $display("FAIL bp_result got %h exp 24", q); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q; int lat, p;
    X_i = share(8'h5A); Y_i = share(8'hC3); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; rnd_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_i = rnd_word; rnd_word = rnd_word + 16'd1;
      @(posedge clk_i); #1;
    end
    rnd_i = rnd_word;
    rst_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || out_valid_o !== 1'b0 || rnd_ready_o !== 1'b0 ||
        g_x_o !== 4'h0 || g_y_o !== 4'h0 || g_z_o !== 16'h0 || Q_o !== '0) begin
      errors++;
      $display("FAIL midreset_state got r=%0b v=%0b rr=%0b z=%h q=%h exp r=1 v=0 rr=0 z=0 q=0",
               ready_o, out_valid_o, rnd_ready_o, g_z_o, Q_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (ready_o !== 1'b1 || out_valid_o !== 1'b0 || rnd_ready_o !== 1'b0 || Q_o !== '0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d got r=%0b v=%0b rr=%0b q=%h exp r=1 v=0 rr=0 q=0",
                 i, ready_o, out_valid_o, rnd_ready_o, Q_o);
      end
    end
    run_op(8'hFF, 8'h0F, 32'h0, 0, q, lat, p);
    checks++;
    if (q !== 8'h0F) begin errors++; $display("FAIL after_reset_result got %h exp 0f", q); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q; int lat, p;
    run_op(8'hFF, 8'hFF, 32'h0, 0, q, lat, p);
    checks++;
    if (q !== 8'hFF) begin errors++; $display("FAIL ones_result got %h exp ff", q); end
    run_op(8'h00, 8'h5A, 32'h0000_0101, 1, q, lat, p);
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL zero_result got %h exp 00", q); end
    checks++;
    if (p !== 8) begin errors++; $display("FAIL zero_pulses got %0d exp 8", p); end
    run_op(8'h81, 8'hF0, 32'h0, 0, q, lat, p);
    checks++;
    if (q !== 8'h80) begin errors++; $display("FAIL edge_bits_result got %h exp 80", q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
